// File: rtl/cla_shared_seq.sv
// cla_shared_seq: two-requester W-bit adder time-sharing one 4-bit CLA slice, one nibble per cycle.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic [3:0] c
);
  logic [3:0] g, p;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = g[0] | (p[0] & c_in);
    c[1] = g[1] | (p[1] & g[0]) | ((&p[1:0]) & c_in);
    c[2] = g[2] | (p[2] & g[1]) | ((&p[2:1]) & g[0]) | ((&p[2:0]) & c_in);
    c[3] = g[3] | (p[3] & g[2]) | ((&p[3:2]) & g[1]) | ((&p[3:1]) & g[0]) | ((&p[3:0]) & c_in);
    sum = p ^ {c[2:0], c_in};
  end
endmodule

module cla_shared_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [1:0]   req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_ovf,
  output logic         rsp_id,
  output logic         busy
);
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_d;
  logic [NIBBLES-1:0][3:0] a_q, b_q, sum_q;
  logic [CW-1:0] cnt;
  logic carry, last_grant, gid, accept;
  logic [3:0] s, c;
  cla4 u_slice (.a(a_q[cnt]), .b(b_q[cnt]), .c_in(carry), .sum(s), .c(c));
  always_comb begin
    gid = req_valid[1] & (~req_valid[0] | ~last_grant);
    accept = (state == IDLE) & (|req_valid);
    req_ready = accept ? (gid ? 2'b10 : 2'b01) : 2'b00;
    state_d = state;
    if (state == IDLE) state_d = accept ? ADD : IDLE;
    else if (state == ADD) state_d = (cnt == LAST) ? DONE : ADD;
    else state_d = rsp_ready ? IDLE : DONE;
    rsp_valid = state == DONE;
    busy = state != IDLE;
    rsp_sum = sum_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      sum_q <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf <= 1'b0;
      rsp_id <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q <= gid ? req_a1 : req_a0;
        b_q <= gid ? req_b1 : req_b0;
        carry <= req_cin[gid];
        rsp_id <= gid;
        last_grant <= gid;
        cnt <= '0;
      end else if (state == ADD) begin
        sum_q[cnt] <= s;
        carry <= c[3];
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          rsp_cout <= c[3];
          rsp_ovf <= c[2] ^ c[3];
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_shared_seq.sv
// tb_cla_shared_seq: directed self-checking bench for cla_shared_seq with NIBBLES=4.
module tb_cla_shared_seq;
  localparam int W = 16;
  logic clk = 0, rst = 1, rsp_ready = 1;
  logic [1:0] req_valid = 0, req_ready, req_cin = 0;
  logic [W-1:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0, rsp_sum;
  logic rsp_valid, rsp_cout, rsp_ovf, rsp_id, busy;
  int checks = 0, fails = 0;

  cla_shared_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_cin(req_cin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int lat);
    if (id) begin req_a1 = a; req_b1 = b; end
    else begin req_a0 = a; req_b0 = b; end
    req_cin = id ? {cin, 1'b0} : {1'b0, cin};
    req_valid = id ? 2'b10 : 2'b01;
    tick;
    req_valid = 0;
    req_a0 = W'($urandom); req_b0 = W'($urandom);
    req_a1 = W'($urandom); req_b1 = W'($urandom);
    req_cin = 2'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
  endtask

  task automatic test_reset;
    rst = 1;
    tick; tick;
    checks++; if (rsp_valid !== 0 || busy !== 0) begin fails++; $display("FAIL reset_state valid=%b busy=%b required 0 0", rsp_valid, busy); end
    checks++; if (rsp_sum !== 0 || rsp_cout !== 0 || rsp_ovf !== 0 || rsp_id !== 0) begin fails++; $display("FAIL reset_rsp sum=%h c=%b o=%b id=%b required 0", rsp_sum, rsp_cout, rsp_ovf, rsp_id); end
    rst = 0;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready_idle got %b required 00", req_ready); end
    tick;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL reset_ready_after got %b required 01", req_ready); end
    req_valid = 0;
    #1;
  endtask

  task automatic test_basic;
    int lat;
    run_op(0, 16'h1234, 16'h4321, 0, lat);
    checks++; if (lat !== 5) begin fails++; $display("FAIL basic_latency got %0d required 5", lat); end
    checks++; if (rsp_sum !== 16'h5555 || rsp_cout !== 0 || rsp_ovf !== 0 || rsp_id !== 0) begin fails++; $display("FAIL basic_result sum=%h c=%b o=%b id=%b required 5555 0 0 0", rsp_sum, rsp_cout, rsp_ovf, rsp_id); end
    checks++; if (busy !== 1 || req_ready !== 2'b00) begin fails++; $display("FAIL basic_done_busy busy=%b ready=%b required 1 00", busy, req_ready); end
    tick;
    checks++; if (rsp_valid !== 0 || busy !== 0 || rsp_sum !== 16'h5555) begin fails++; $display("FAIL basic_retain valid=%b busy=%b sum=%h required 0 0 5555", rsp_valid, busy, rsp_sum); end
  endtask

  task automatic test_carry;
    int lat;
    run_op(0, 16'hFFFF, 16'h0001, 0, lat);
    checks++; if (rsp_sum !== 16'h0000 || rsp_cout !== 1 || rsp_ovf !== 0) begin fails++; $display("FAIL carry_chain sum=%h c=%b o=%b required 0000 1 0", rsp_sum, rsp_cout, rsp_ovf); end
    tick;
    run_op(1, 16'hFFFF, 16'h0000, 1, lat);
    checks++; if (rsp_sum !== 16'h0000 || rsp_cout !== 1 || rsp_ovf !== 0 || rsp_id !== 1) begin fails++; $display("FAIL carry_cin sum=%h c=%b o=%b id=%b required 0000 1 0 1", rsp_sum, rsp_cout, rsp_ovf, rsp_id); end
    tick;
  endtask

  task automatic test_ovf;
    int lat;
    run_op(0, 16'h7FFF, 16'h0001, 0, lat);
    checks++; if (rsp_sum !== 16'h8000 || rsp_cout !== 0 || rsp_ovf !== 1) begin fails++; $display("FAIL ovf_pos sum=%h c=%b o=%b required 8000 0 1", rsp_sum, rsp_cout, rsp_ovf); end
    tick;
    run_op(1, 16'h8000, 16'h8000, 0, lat);
    checks++; if (rsp_sum !== 16'h0000 || rsp_cout !== 1 || rsp_ovf !== 1) begin fails++; $display("FAIL ovf_neg sum=%h c=%b o=%b required 0000 1 1", rsp_sum, rsp_cout, rsp_ovf); end
    tick;
    run_op(0, 16'h0F0F, 16'h10F0, 1, lat);
    checks++; if (rsp_sum !== 16'h2000 || rsp_cout !== 0 || rsp_ovf !== 0) begin fails++; $display("FAIL mixed_add sum=%h c=%b o=%b required 2000 0 0", rsp_sum, rsp_cout, rsp_ovf); end
    tick;
  endtask

  task automatic test_back_to_back;
    int n;
    rst = 1; tick; rst = 0;
    req_a0 = 16'h0001; req_b0 = 16'h0001; req_a1 = 16'h0010; req_b1 = 16'h0010; req_cin = 0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (req_ready !== (k[0] ? 2'b10 : 2'b01)) begin fails++; $display("FAIL b2b_ready k=%0d got %b required %b", k, req_ready, k[0] ? 2'b10 : 2'b01); end
      n = 0;
      do begin tick; n++; end while (!rsp_valid && n < 20);
      checks++; if (n !== 5) begin fails++; $display("FAIL b2b_spacing k=%0d got %0d required 5", k, n); end
      checks++; if (rsp_id !== k[0] || rsp_sum !== (k[0] ? 16'h0020 : 16'h0002)) begin fails++; $display("FAIL b2b_result k=%0d id=%b sum=%h required %b %h", k, rsp_id, rsp_sum, k[0], k[0] ? 16'h0020 : 16'h0002); end
      tick;
    end
    req_valid = 0;
    tick; tick;
  endtask

  task automatic test_backpressure;
    int lat;
    rsp_ready = 0;
    run_op(0, 16'h1111, 16'h2222, 0, lat);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_valid !== 1 || rsp_sum !== 16'h3333 || rsp_cout !== 0 || rsp_ovf !== 0 || rsp_id !== 0) begin fails++; $display("FAIL bp_hold i=%0d valid=%b sum=%h c=%b o=%b id=%b required 1 3333 0 0 0", i, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id); end
      checks++; if (req_ready !== 2'b00 || busy !== 1) begin fails++; $display("FAIL bp_busy i=%0d ready=%b busy=%b required 00 1", i, req_ready, busy); end
      tick;
    end
    req_valid = 0;
    rsp_ready = 1;
    tick;
    checks++; if (busy !== 0 || rsp_valid !== 0) begin fails++; $display("FAIL bp_release busy=%b valid=%b required 0 0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic seen;
    req_a0 = 16'hAAAA; req_b0 = 16'h5555; req_cin = 0;
    req_valid = 2'b01;
    tick;
    req_valid = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    checks++; if (rsp_valid !== 0 || busy !== 0 || rsp_sum !== 0) begin fails++; $display("FAIL mid_reset valid=%b busy=%b sum=%h required 0 0 0000", rsp_valid, busy, rsp_sum); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick; seen |= rsp_valid | busy; end
    checks++; if (seen !== 0) begin fails++; $display("FAIL mid_no_rsp got %b required 0", seen); end
    run_op(1, 16'h0F0F, 16'h00F1, 0, lat);
    checks++; if (lat !== 5 || rsp_sum !== 16'h1000 || rsp_id !== 1 || rsp_cout !== 0) begin fails++; $display("FAIL mid_next lat=%0d sum=%h id=%b c=%b required 5 1000 1 0", lat, rsp_sum, rsp_id, rsp_cout); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ovf;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
